// File: rtl/sc_dot_engine.sv
// Stochastic-computing dot product: sum over pairs of (a_i*b_i)/2^W, estimated
// by counting AND-ed unary comparator streams over 2^(W-k) cycles.
// Latency: 2^(W-k)+1 edges from start to result-valid. No backpressure: while
// busy, all inputs are ignored; en_in in IDLE (including the en_out cycle) starts.
module sc_dot_engine #(
    parameter  int N_PAIRS   = 4,
    parameter  int W         = 6,
    parameter  int MAX_TRUNC = 3,
    localparam int TW        = (MAX_TRUNC > 0) ? $clog2(MAX_TRUNC + 1) : 1,
    localparam int RW        = W + $clog2(N_PAIRS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_in,
    input  logic [TW-1:0]          trunc,
    input  logic [N_PAIRS*W-1:0]   a_vec,
    input  logic [N_PAIRS*W-1:0]   b_vec,
    output logic                   busy,
    output logic                   en_out,
    output logic [RW-1:0]          result
);

    // Width of the per-cycle count of set stream bits (0..N_PAIRS).
    localparam int CW = $clog2(N_PAIRS) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [TW-1:0] K_MAX = TW'(MAX_TRUNC);

    logic [1:0]           r_state;
    logic [N_PAIRS*W-1:0] r_a;
    logic [N_PAIRS*W-1:0] r_b;
    logic [TW-1:0]        r_k;
    logic [W-1:0]         r_c;
    logic [RW-1:0]        r_acc;
    logic [RW-1:0]        r_result;
    logic                 r_en_out;

    logic [TW-1:0]        w_k_sel;
    logic [W-1:0]         w_ra;
    logic [W-1:0]         w_rb;
    logic [W-1:0]         w_last_c;
    logic [N_PAIRS-1:0]   w_s;
    logic [CW-1:0]        w_cnt;
    logic                 w_start;

    // Requested truncation, saturated at the largest supported reduction.
    assign w_k_sel  = (trunc > K_MAX) ? K_MAX : trunc;
    assign w_start  = (r_state == S_IDLE) && en_in;

    // Sequence ends at c = 2^L - 1, i.e. all-ones shifted down by k.
    assign w_last_c = {W{1'b1}} >> r_k;

    // First threshold: c scaled up to the full operand range.
    assign w_ra     = r_c << r_k;

    // Second threshold: bitrev_L(c) << k equals a full W-bit reversal of c,
    // because c < 2^L keeps the reversed bits out of the low k positions.
    always_comb begin
        w_rb = '0;
        for (int j = 0; j < W; j++) begin
            w_rb[j] = r_c[W-1-j];
        end
    end

    // Per-pair stream bit: both operands exceed their respective thresholds.
    always_comb begin
        w_s = '0;
        for (int i = 0; i < N_PAIRS; i++) begin
            w_s[i] = (r_a[i*W +: W] > w_ra) && (r_b[i*W +: W] > w_rb);
        end
    end

    // Count how many pairs contribute a one this cycle.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N_PAIRS; i++) begin
            w_cnt = w_cnt + CW'(w_s[i]);
        end
    end

    // Control FSM: capture on start, sweep the sequence, publish, return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_c     <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_a     <= a_vec;
                        r_b     <= b_vec;
                        r_k     <= w_k_sel;
                        r_c     <= '0;
                        r_acc   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Cannot overflow: each pair contributes at most 2^L-1.
                    r_acc <= r_acc + RW'(w_cnt);
                    if (r_c == w_last_c) begin
                        r_c     <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_c <= r_c + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result register and one-cycle valid pulse, issued from DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= '0;
            r_en_out <= 1'b0;
        end else begin
            r_en_out <= 1'b0;
            if (r_state == S_DONE) begin
                // Rescale the shortened stream count back to full 2^W units.
                r_result <= r_acc << r_k;
                r_en_out <= 1'b1;
            end
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign en_out = r_en_out;
    assign result = r_result;

endmodule

// File: doc/sc_dot_engine.md
SC_DOT_ENGINE -- requirements
Module: sc_dot_engine

Interface
REQ-001 SHALL have parameter N_PAIRS, default 4: number of multiply pairs summed (>=2, power of two).
REQ-002 SHALL have parameter W, default 6: operand width; operand value v means v/2^W.
REQ-003 SHALL have parameter MAX_TRUNC, default 3: largest stream-length reduction allowed (0..W-1).
REQ-004 SHALL have port clk  input  1: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port en_in  input  1: start request, sampled only in IDLE.
REQ-007 SHALL have port trunc  input  clog2(MAX_TRUNC+1): stream-length reduction k, sampled with en_in.
REQ-008 SHALL have port a_vec  input  N_PAIRS*W: operands a_i; pair i occupies bits [i*W +: W].
REQ-009 SHALL have port b_vec  input  N_PAIRS*W: operands b_i; same packing as a_vec.
REQ-010 SHALL have port busy  output  1: high in RUN and DONE.
REQ-011 SHALL have port en_out  output  1: one-cycle result-valid pulse.
REQ-012 SHALL have port result  output  RW = W+clog2(N_PAIRS): scaled dot product, default width 8.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 SHALL in IDLE with en_in=1 capture a_vec, b_vec and k = min(trunc, MAX_TRUNC), clear the sequence counter c and all accumulators, and enter RUN.
REQ-015 SHALL define L = W-k and run exactly 2^L RUN cycles, c = 0..2^L-1, one value per cycle.
REQ-016 SHALL per RUN cycle form thresholds ra = c<<k and rb = bitrev_L(c)<<k, both W bits wide.
REQ-017 SHALL per pair form stream bit s_i = (a_i > ra) AND (b_i > rb), using unsigned comparisons.
REQ-018 SHALL add the sum of all s_i for the cycle into one accumulator of width RW; the accumulator cannot overflow, since each pair counts at most 2^L-1.
REQ-019 SHALL leave RUN for DONE on the edge that processes c = 2^L-1.
REQ-020 SHALL in DONE register result = accumulator<<k (truncated to RW bits), assert en_out for exactly one cycle, and return to IDLE.
REQ-021 SHALL give latency: en_in sampled at edge T0 -> en_out high in the cycle after edge T0+2^L+1; for W=6 and k=0 that is 65 edges.
REQ-022 SHALL hold result stable from the en_out pulse until the next en_out pulse.
REQ-023 SHALL ignore en_in, trunc, a_vec and b_vec while busy=1; input changes in RUN do not affect the result.
REQ-024 SHALL accept en_in=1 in the IDLE cycle in which en_out=1, giving back-to-back operation with no dead cycle.
REQ-025 SHALL clamp trunc values above MAX_TRUNC to MAX_TRUNC.
REQ-026 SHALL produce result 0 when every pair has a_i=0 or b_i=0.

Reset
REQ-027 SHALL on rst=0 immediately set state=IDLE, c=0, accumulator=0, result=0, en_out=0 and busy=0, independent of clk.
REQ-028 SHALL abort any operation in progress on reset mid-RUN or mid-DONE, with no en_out pulse for that operation.
REQ-029 SHALL require a fresh en_in after reset release before any computation starts; en_in held at 1 through release starts on the first edge with rst=1.

Verification
REQ-030 Default parameters, all a_i=b_i=32, trunc=0, en_in pulse -> en_out after 65 edges, result=64.
REQ-031 All a_i=b_i=63, trunc=0 -> result=252; all a_i=0 with any b_i -> result=0.
REQ-032 All a_i=b_i=32, trunc=1 -> en_out after 33 edges, result=64; trunc=3 (MAX) -> en_out after 9 edges.
REQ-033 en_in held high continuously with random operands -> en_out pulses every 66 cycles, and each result matches a bit-exact reference model of REQ-015..REQ-020.
REQ-034 rst pulsed low at c=20 of a RUN -> outputs zero asynchronously, no en_out, and the next operation is correct.
REQ-035 Change a_vec and b_vec every cycle during RUN -> result equals the value for the captured operands; 1000 random trials -> mean absolute error against (sum a_i*b_i)/2^W is at most N_PAIRS per trial.
